interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

CPU-side receiver for the peripheral interrupt interface driven by devices such as the keyboard. It accepts the active-low `interruptSignal` request, the 4-bit `interruptIndex` and the 16-bit `data` payload. Each request edge is captured into a small FIFO so that no event is lost while the CPU is busy. The head entry is presented to the CPU through a pending/acknowledge handshake.

## Interface

**Parameters**

- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥2.
- `ADDR_W`, default 2: log2(`DEPTH`).

**Ports**

- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `interruptSignal` in 1: device request, active-low.
- `interruptIndex` in 4: source index, valid while `interruptSignal`=0.
- `data` in 16: payload, valid while `interruptSignal`=0.
- `intMask` in 16: per-index enable; bit i=1 accepts index i.
- `intAck` in 1: CPU pops the head entry; active-high, one cycle per pop.
- `intPending` out 1: FIFO non-empty.
- `intIndex` out 4: index of the head entry.
- `intData` out 16: payload of the head entry.
- `fifoCount` out ADDR_W+1: number of stored entries, 0..DEPTH.
- `overflowCount` out 8: dropped-request counter (see Configuration).

## Operation

- **Request detection**
  - Register `prevSignal` holds `interruptSignal` from the previous cycle; its reset value is 1.
  - A request is accepted at an edge when `interruptSignal`=0, `prevSignal`=1 and `intMask[interruptIndex]`=1.
  - A low level held for several cycles is one request. Back-to-back single-cycle pulses separated by at least one high cycle are separate requests.
  - A masked request is discarded silently and is not counted as overflow.
- **FIFO**
  - Circular buffer with `wrPtr` and `rdPtr` of ADDR_W bits each; both wrap from DEPTH-1 to 0.
  - `fifoCount` is tracked separately to distinguish full from empty.
  - Push: writes {`interruptIndex`, `data`} at `wrPtr`, then increments `wrPtr`.
  - Pop: requires `intAck`=1 and `fifoCount`>0; increments `rdPtr`.
  - The head is first-word fall-through: `intIndex`/`intData` are read combinationally at `rdPtr`. They are 0 when the FIFO is empty.
- **Boundary rules**
  - Push only: `fifoCount`+1.
  - Pop only: `fifoCount`-1.
  - Push and pop in the same cycle: both occur and `fifoCount` is unchanged. This includes the full case: when full, the pop frees the slot and the push is accepted.
  - Push while full with no pop: the request is dropped, pointers are unchanged, and the overflow event is flagged.
  - `intAck` while empty: ignored.
  - `intAck` held high pops one entry per cycle until the FIFO is empty.
- **Reset**
  - Asserting `rst`=0 at any time, including mid-burst, clears pointers, `fifoCount`, `prevSignal`=1 and `overflowCount`.
  - All stored entries are lost.
  - Outputs after reset: `intPending`=0, `intIndex`=0, `intData`=0, `fifoCount`=0, `overflowCount`=0.

## Timing

- **Request to pending latency:** 1 edge. A request sampled at edge N makes `intPending`=1 and the head valid immediately after edge N.
- **Pop:** `intAck` sampled at edge N. The next entry, or the empty state, is visible after edge N.
- **Combinational paths:** `intPending`, `intIndex`, `intData` and `fifoCount` depend only on registers; there is no path from inputs to outputs.
- **Throughput:** one push and one pop per cycle.

## Configuration

- **Macro:** `INTC_OVERFLOW_COUNT_EN`.
- **Defined:** `overflowCount` is an 8-bit counter incremented on each dropped-when-full request. It saturates at 255 and is cleared only by reset.
- **Undefined:** the counter logic is not built and `overflowCount` is tied to 0. All other behaviour is identical.

## Test plan

- **Single request.** After reset, drive `interruptSignal` low for 1 cycle with index 0, data 0x1234 and mask 0xFFFF. Required: after the next edge `intPending`=1, `intIndex`=0, `intData`=0x1234, `fifoCount`=1. Pulse `intAck`: `intPending`=0 and `intData`=0.
- **Edge versus level.** Hold `interruptSignal` low for 5 cycles with data 0xAAAA. Required: `fifoCount`=1. Then go high 1 cycle and low 1 cycle with data 0xBBBB. Required: `fifoCount`=2, with head order 0xAAAA then 0xBBBB.
- **Overflow.** With DEPTH=4 and no ack, send 6 single-cycle requests with data 1..6. Required: `fifoCount`=4, entries pop in order 1,2,3,4, and `overflowCount`=2 (0 if the macro is undefined).
- **Full with simultaneous push/pop.** Fill to 4, then assert `intAck` in the same cycle as a new request with data 0x55. Required: `fifoCount` stays 4, `overflowCount` is unchanged, and 0x55 is the last entry popped.
- **Mask and wrap-around.** With `intMask`=0xFFFE, a request with index 0 is not stored. Then run 10 push/pop pairs with index 3. Required: pointers wrap correctly and every popped datum matches the value pushed.
- **Reset mid-operation.** With 3 entries stored, pulse `rst` low between edges. Required: all outputs 0 immediately. A low `interruptSignal` already present when reset releases is accepted on the first edge, because `prevSignal` resets to 1.

Source files
------------

// File: rtl/interrupt_controller.sv
// Peripheral interrupt receiver: edge-detected, masked requests queued in a FIFO with a pending/ack head.
// Optional saturating drop counter is enabled by defining INTC_OVERFLOW_COUNT_EN.
module interrupt_controller #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              interruptSignal,
    input  logic [3:0]        interruptIndex,
    input  logic [15:0]       data,
    input  logic [15:0]       intMask,
    input  logic              intAck,
    output logic              intPending,
    output logic [3:0]        intIndex,
    output logic [15:0]       intData,
    output logic [ADDR_W:0]   fifoCount,
    output logic [7:0]        overflowCount
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic              r_prevSignal;
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_count;
    logic [3:0]        r_memIndex [DEPTH];
    logic [15:0]       r_memData  [DEPTH];

    logic w_request;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    // A falling edge of the active-low request, filtered by the per-index mask.
    assign w_request = !interruptSignal && r_prevSignal && intMask[interruptIndex];
    assign w_full    = (r_count == FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign w_pop     = intAck && !w_empty;
    assign w_push    = w_request && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prevSignal <= 1'b1;
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
        end else begin
            r_prevSignal <= interruptSignal;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head outputs are forced to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memIndex[r_wrPtr] <= interruptIndex;
            r_memData[r_wrPtr]  <= data;
        end
    end

    assign intPending = !w_empty;
    assign intIndex   = w_empty ? 4'h0  : r_memIndex[r_rdPtr];
    assign intData    = w_empty ? 16'h0 : r_memData[r_rdPtr];
    assign fifoCount  = r_count;

`ifdef INTC_OVERFLOW_COUNT_EN
    logic       w_drop;
    logic [7:0] r_overflowCount;

    assign w_drop = w_request && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflowCount <= 8'h00;
        end else if (w_drop && (r_overflowCount != 8'hFF)) begin
            r_overflowCount <= r_overflowCount + 8'h01;
        end
    end

    assign overflowCount = r_overflowCount;
`else
    assign overflowCount = 8'h00;
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: stimulus queues expected heads, a monitor checks each pop.
module tb_interrupt_controller;

    logic        clk;
    logic        rst;
    logic        interruptSignal;
    logic [3:0]  interruptIndex;
    logic [15:0] data;
    logic [15:0] intMask;
    logic        intAck;
    logic        intPending;
    logic [3:0]  intIndex;
    logic [15:0] intData;
    logic [2:0]  fifoCount;
    logic [7:0]  overflowCount;

    int checks   = 0;
    int failures = 0;
    logic [19:0] expQ [$];
    logic [7:0]  expOverflow;

`ifdef INTC_OVERFLOW_COUNT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    interrupt_controller #(.DEPTH(4), .ADDR_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .interruptSignal (interruptSignal),
        .interruptIndex  (interruptIndex),
        .data            (data),
        .intMask         (intMask),
        .intAck          (intAck),
        .intPending      (intPending),
        .intIndex        (intIndex),
        .intData         (intData),
        .fifoCount       (fifoCount),
        .overflowCount   (overflowCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One masked-or-not request: low for one cycle, then high for one cycle.
    task automatic applyStimulus(input logic [3:0] idx, input logic [15:0] dat, input bit accepted);
        interruptSignal = 1'b0;
        interruptIndex  = idx;
        data            = dat;
        if (accepted) expQ.push_back({idx, dat});
        tick();
        interruptSignal = 1'b1;
        tick();
    endtask

    task automatic ackCycles(input int n);
        intAck = 1'b1;
        repeat (n) tick();
        intAck = 1'b0;
    endtask

    // Monitor: every acknowledged head is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst && intAck && intPending) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL popUnexpected actual=%0h required=none", {intIndex, intData});
            end else begin
                logic [19:0] e;
                e = expQ.pop_front();
                checkOutput("popIndex", 32'(intIndex), 32'(e[19:16]));
                checkOutput("popData",  32'(intData),  32'(e[15:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst             = 1'b0;
        interruptSignal = 1'b1;
        interruptIndex  = 4'h0;
        data            = 16'h0;
        intMask         = 16'hFFFF;
        intAck          = 1'b0;
        expOverflow     = 8'h00;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        checkOutput("rstPending",  32'(intPending),    32'h0);
        checkOutput("rstIndex",    32'(intIndex),      32'h0);
        checkOutput("rstData",     32'(intData),       32'h0);
        checkOutput("rstCount",    32'(fifoCount),     32'h0);
        checkOutput("rstOverflow", 32'(overflowCount), 32'h0);

        // Single request, visible right after the sampling edge.
        interruptSignal = 1'b0;
        interruptIndex  = 4'h0;
        data            = 16'h1234;
        expQ.push_back({4'h0, 16'h1234});
        tick();
        interruptSignal = 1'b1;
        checkOutput("singlePending", 32'(intPending), 32'h1);
        checkOutput("singleIndex",   32'(intIndex),   32'h0);
        checkOutput("singleData",    32'(intData),    32'h1234);
        checkOutput("singleCount",   32'(fifoCount),  32'h1);
        ackCycles(1);
        checkOutput("singleAckPending", 32'(intPending), 32'h0);
        checkOutput("singleAckData",    32'(intData),    32'h0);

        // A long low level is a single request.
        interruptSignal = 1'b0;
        interruptIndex  = 4'h5;
        data            = 16'hAAAA;
        expQ.push_back({4'h5, 16'hAAAA});
        repeat (5) tick();
        checkOutput("levelCount", 32'(fifoCount), 32'h1);
        interruptSignal = 1'b1;
        tick();
        interruptSignal = 1'b0;
        data            = 16'hBBBB;
        expQ.push_back({4'h5, 16'hBBBB});
        tick();
        interruptSignal = 1'b1;
        checkOutput("edgeCount", 32'(fifoCount), 32'h2);
        checkOutput("edgeHead",  32'(intData),   32'hAAAA);
        ackCycles(2);
        checkOutput("edgeDrained", 32'(fifoCount), 32'h0);

        // Overflow: six requests into four slots with no ack.
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(4'h1, 16'(i), i <= 4);
        end
        if (OVF_EN) expOverflow = 8'd2;
        checkOutput("ovfCount",    32'(fifoCount),     32'h4);
        checkOutput("ovfCounter",  32'(overflowCount), 32'(expOverflow));
        checkOutput("ovfHead",     32'(intData),       32'h1);
        ackCycles(4);
        checkOutput("ovfDrained",  32'(fifoCount),     32'h0);
        checkOutput("ovfHeld",     32'(overflowCount), 32'(expOverflow));
        ackCycles(1);
        checkOutput("ackEmpty",    32'(fifoCount),     32'h0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'h2, 16'h10 + 16'(i), 1'b1);
        end
        checkOutput("fullCount", 32'(fifoCount), 32'h4);
        interruptSignal = 1'b0;
        interruptIndex  = 4'h2;
        data            = 16'h55;
        intAck          = 1'b1;
        expQ.push_back({4'h2, 16'h55});
        tick();
        interruptSignal = 1'b1;
        intAck          = 1'b0;
        checkOutput("fullPushPopCount", 32'(fifoCount),     32'h4);
        checkOutput("fullPushPopOvf",   32'(overflowCount), 32'(expOverflow));
        ackCycles(4);
        checkOutput("fullDrained", 32'(fifoCount), 32'h0);

        // Masked index 0 is dropped silently, then pointers wrap through ten pairs.
        intMask = 16'hFFFE;
        applyStimulus(4'h0, 16'hDEAD, 1'b0);
        checkOutput("maskCount", 32'(fifoCount),     32'h0);
        checkOutput("maskOvf",   32'(overflowCount), 32'(expOverflow));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'h3, 16'h300 + 16'(i), 1'b1);
            checkOutput("wrapPushCount", 32'(fifoCount), 32'h1);
            ackCycles(1);
        end
        checkOutput("wrapDrained", 32'(fifoCount), 32'h0);
        intMask = 16'hFFFF;

        // Reset with three entries; the request level still low afterwards must be re-accepted.
        applyStimulus(4'h4, 16'h41, 1'b1);
        applyStimulus(4'h4, 16'h42, 1'b1);
        interruptSignal = 1'b0;
        interruptIndex  = 4'h4;
        data            = 16'h43;
        tick();
        checkOutput("preResetCount", 32'(fifoCount), 32'h3);
        #1 rst = 1'b0;
        #1;
        expQ.delete();
        checkOutput("midRstPending",  32'(intPending),    32'h0);
        checkOutput("midRstIndex",    32'(intIndex),      32'h0);
        checkOutput("midRstData",     32'(intData),       32'h0);
        checkOutput("midRstCount",    32'(fifoCount),     32'h0);
        checkOutput("midRstOverflow", 32'(overflowCount), 32'h0);
        expOverflow = 8'h00;
        interruptIndex = 4'h6;
        data           = 16'h7777;
        #1 rst = 1'b1;
        expQ.push_back({4'h6, 16'h7777});
        tick();
        interruptSignal = 1'b1;
        checkOutput("postRstCount", 32'(fifoCount), 32'h1);
        checkOutput("postRstData",  32'(intData),   32'h7777);
        ackCycles(1);
        checkOutput("finalCount",   32'(fifoCount), 32'h0);
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'h0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
